// File: rtl/cpu_mux_pkg.sv
// Shared constants for the pipelined N-to-1 channel mux.
// Round-robin support is compiled in only when PIPE_MUX_RR_EN is defined.
package cpu_mux_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NCH   = 4;
  localparam int CNT_W     = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first valid channel at or after ptr, wrapping.
// Only built with PIPE_MUX_RR_EN; the fixed-select build has no use for it.
`ifdef PIPE_MUX_RR_EN
module rr_pick #(
  parameter int NCH = 4,
  parameter int SW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] valid,
  input  logic [SW-1:0]  ptr,
  output logic [SW-1:0]  idx,
  output logic           found
);

  // Walk offsets from the far end so the nearest candidate to ptr wins last.
  always_comb begin
    int k;
    found = 1'b0;
    idx   = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % NCH;
      if (valid[k]) begin
        found = 1'b1;
        idx   = SW'(k);
      end
    end
  end

endmodule
`endif

// File: rtl/pipe_mux_n_to_1.sv
// Pipelined N-to-1 mux with a one-word output register; fixed select or round-robin.
// Round-robin arbitration and the ptr register exist only when PIPE_MUX_RR_EN is defined.
module pipe_mux_n_to_1
  import cpu_mux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCH   = DEF_NCH,
  parameter int SW    = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic [SW-1:0]        sel,
  input  logic                 mode,
  output logic [WIDTH-1:0]     out_data,
  output logic [SW-1:0]        out_ch,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_W-1:0]     accept_cnt
);

  logic             slot_free;
  logic             have_fixed;
  logic             have_c;
  logic             accept;
  logic [SW-1:0]    c;
  logic [WIDTH-1:0] ch_word [NCH];

  for (genvar k = 0; k < NCH; k++) begin : g_word
    assign ch_word[k] = in_data[k*WIDTH +: WIDTH];
  end

  assign slot_free  = !out_valid || out_ready;
  assign have_fixed = (32'(sel) < NCH);

`ifdef PIPE_MUX_RR_EN
  logic [SW-1:0] ptr;
  logic [SW-1:0] rr_idx;
  logic          rr_found;

  rr_pick #(.NCH(NCH), .SW(SW)) u_rr_pick (
    .valid (in_valid),
    .ptr   (ptr),
    .idx   (rr_idx),
    .found (rr_found)
  );

  // Mode switches the choice in the same cycle; ptr is kept across switches.
  always_comb begin
    if (mode) begin
      c      = rr_idx;
      have_c = rr_found;
    end else begin
      c      = sel;
      have_c = have_fixed;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept && mode) begin
      ptr <= (32'(c) == NCH - 1) ? '0 : c + SW'(1);
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign c           = sel;
  assign have_c      = have_fixed;
`endif

  always_comb begin
    in_ready = '0;
    if (have_c && slot_free && !rst) begin
      in_ready[c] = 1'b1;
    end
  end

  assign accept = have_c && slot_free && !rst && in_valid[c];

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_ch     <= '0;
      accept_cnt <= '0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_data   <= ch_word[c];
      out_ch     <= c;
      accept_cnt <= accept_cnt + CNT_W'(1);
    end else if (slot_free) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: doc/pipe_mux_n_to_1.md
PIPE_MUX_N_TO_1 -- requirements
Module: pipe_mux_n_to_1

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: data width per channel in bits.
REQ-002 The block SHALL have parameter NCH, default 4: number of input channels, 2..16.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_data, input, NCH*WIDTH bits: channel k occupies bits [k*WIDTH +: WIDTH].
REQ-006 The block SHALL have port in_valid, input, NCH bits: per-channel data valid.
REQ-007 The block SHALL have port in_ready, output, NCH bits: per-channel accept, combinational.
REQ-008 The block SHALL have port sel, input, clog2(NCH) bits: channel index in fixed mode.
REQ-009 The block SHALL have port mode, input, 1 bit: 0 = fixed select, 1 = round-robin.
REQ-010 The block SHALL have port out_data, output, WIDTH bits: registered selected word.
REQ-011 The block SHALL have port out_ch, output, clog2(NCH) bits: source channel of out_data.
REQ-012 The block SHALL have port out_valid, output, 1 bit: out_data holds an unconsumed word.
REQ-013 The block SHALL have port out_ready, input, 1 bit: downstream consumes the word when out_valid and out_ready are both high.
REQ-014 The block SHALL have port accept_cnt, output, 16 bits: count of accepted input words, wrapping.

Function
REQ-015 The slot SHALL be free when out_valid=0 or out_ready=1.
REQ-016 Chosen channel c SHALL be sel in fixed mode, or the first channel with in_valid=1 at or after ptr (ascending, wrapping NCH-1 to 0) in round-robin mode.
REQ-017 in_ready[c] SHALL equal slot free; all other in_ready bits SHALL be 0.
REQ-018 No channel SHALL be chosen, and in_ready SHALL be all 0, when sel >= NCH in fixed mode or when no in_valid bit is set in round-robin mode.
REQ-019 An accept SHALL occur when in_valid[c]=1 and in_ready[c]=1.
REQ-020 On an accept, the next edge SHALL load out_data<=in_data[c], out_ch<=c, out_valid<=1, and increment accept_cnt (0xFFFF wraps to 0x0000).
REQ-021 Latency SHALL be 1 cycle from accept to out_valid, with throughput 1 word/cycle under continuous out_ready=1.
REQ-022 When the slot is free with no accept, out_valid SHALL go 0 at the next edge; out_data and out_ch SHALL hold.
REQ-023 While out_valid=1 and out_ready=0, out_data, out_ch and out_valid SHALL hold regardless of sel, mode or in_* changes.
REQ-024 On an accept in round-robin mode, ptr SHALL become (c+1) mod NCH; otherwise ptr SHALL hold.
REQ-025 A change of mode SHALL take effect on the selection of the same cycle, with ptr retained across mode changes.
REQ-026 Consume and accept in the same cycle SHALL replace the word with no bubble.

Reset
REQ-027 While rst=1, at each edge: out_valid=0, out_data=0, out_ch=0, ptr=0, accept_cnt=0.
REQ-028 While rst=1, in_ready SHALL be all 0.
REQ-029 Assertion of rst while a word is held SHALL discard that word.

Configuration
REQ-030 Macro PIPE_MUX_RR_EN SHALL control round-robin support.
REQ-031 With PIPE_MUX_RR_EN defined, behaviour SHALL be as in REQ-016/024.
REQ-032 Without PIPE_MUX_RR_EN, the mode port SHALL remain present but be ignored: fixed select always, no ptr register.

Structure
REQ-033 Package cpu_mux_pkg SHALL hold the default WIDTH/NCH constants and the accept_cnt width constant (16).
REQ-034 Sub-module rr_pick SHALL compute the round-robin choice: in_valid plus ptr in, channel index plus found flag out, purely combinational.

Verification (WIDTH=8, NCH=4)
REQ-035 Fixed mode: sel=2, in_valid=0100, ch2=0x44, out_ready=1 -> next cycle out_data=0x44, out_ch=2, accept_cnt=1.
REQ-036 Backpressure: out_valid=1 holding 0x99, out_ready=0, ch1 valid with 0x83, sel=1 -> in_ready=0000 and 0x99 held; out_ready=1 -> 0x83 loaded with no bubble.
REQ-037 Round-robin: mode=1, all valid, out_ready=1 for 6 cycles -> out_ch sequence 0,1,2,3,0,1.
REQ-038 Round-robin skip: ptr=3, in_valid=0010 -> c=1, then ptr=2.
REQ-039 Reset mid-hold: out_valid=1 holding 0xE2, rst=1 for one cycle -> out_valid=0, out_data=0x00, accept_cnt=0.
REQ-040 Counter wrap: preload 65535 accepts -> accept_cnt=0xFFFF; next accept -> 0x0000.
